// File: rtl/gcm_pkg.sv
// Shared types and helpers for the GCM receive-side GCTR engine.
package gcm_pkg;

    localparam int unsigned BLOCK_W = 128;
    localparam int unsigned INC_S   = 32;
    localparam int unsigned BYTES_W = 5;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} gctr_state_e;

    // Increment the right-most INC_S bits modulo 2^INC_S; upper bits pass through.
    function automatic logic [BLOCK_W-1:0] inc32(input logic [BLOCK_W-1:0] cb);
        return {cb[BLOCK_W-1:INC_S], cb[INC_S-1:0] + INC_S'(1)};
    endfunction

    // Ones in the most-significant 'bytes' bytes, zeros below.
    function automatic logic [BLOCK_W-1:0] mask_msb(input logic [BYTES_W-1:0] bytes);
        logic [BLOCK_W-1:0] m;
        m = '0;
        for (int i = 0; i < int'(BLOCK_W / 8); i++) begin
            if (BYTES_W'(i) < bytes) begin
                m[BLOCK_W-1-8*i -: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/gcm_sync_fifo.sv
// Synchronous fall-through FIFO with active-high synchronous reset.
// Pushes while full are dropped; the caller is expected to prevent them.
module gcm_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign data_o  = mem_q[rd_ptr_q];

    // Storage array; contents need no reset since empty_o qualifies the head.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/gctr_decrypt_stream.sv
// GCM receive-side GCTR engine: counter generation, AES request issue and
// keystream XOR with credit-based flow control toward a fixed-latency AES core.
// Optional feature macro: GCTR_DEC_PARTIAL_EN (mask unused bytes of the last block).
module gctr_decrypt_stream
    import gcm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = BLOCK_W,
    parameter int unsigned S          = INC_S,
    parameter int unsigned CIPH_LAT   = 12,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] icb_in,
    input  logic                  ct_valid,
    output logic                  ct_ready,
    input  logic [DATA_WIDTH-1:0] ct_data,
    input  logic                  ct_last,
    input  logic [BYTES_W-1:0]    ct_bytes,
    output logic                  ciph_valid_out,
    output logic [DATA_WIDTH-1:0] ciph_block_out,
    input  logic                  ciph_valid_in,
    input  logic [DATA_WIDTH-1:0] ciph_block_in,
    output logic                  pt_valid,
    input  logic                  pt_ready,
    output logic [DATA_WIDTH-1:0] pt_data,
    output logic                  pt_last,
    output logic                  busy
);
    localparam int unsigned OW = $clog2(DEPTH + 1);
`ifdef GCTR_DEC_PARTIAL_EN
    localparam int unsigned CT_W = DATA_WIDTH + 1 + BYTES_W;
`else
    localparam int unsigned CT_W = DATA_WIDTH + 1;
`endif

    gctr_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] cb_q, cb_d, cb_inc;
    logic [OW-1:0]         outst_q, outst_d;
    logic [CIPH_LAT-1:0]   pend_q;
    logic                  ciph_valid_q;
    logic [DATA_WIDTH-1:0] ciph_block_q;
    logic                  accept, pt_fire, ks_push;
    logic                  ks_full, ks_empty, ct_empty, unused_ct_full;
    logic [CT_W-1:0]       ct_wdata, ct_rdata;
    logic [DATA_WIDTH-1:0] ks_rdata, ct_head, pt_raw;
    logic                  ct_head_last;

    if (DATA_WIDTH == BLOCK_W && S == INC_S) begin : g_inc32
        assign cb_inc = inc32(cb_q);
    end else begin : g_incs
        assign cb_inc = {cb_q[DATA_WIDTH-1:S], cb_q[S-1:0] + S'(1)};
    end

    assign ct_ready = (state_q == RUN) && (outst_q < OW'(DEPTH));
    assign accept   = ct_valid & ct_ready;
    assign pt_valid = ~ct_empty & ~ks_empty;
    assign pt_fire  = pt_valid & pt_ready;
    // Only keystream matching a request issued since the last reset is accepted.
    assign ks_push  = ciph_valid_in & pend_q[CIPH_LAT-1];

    assign ct_head      = ct_rdata[CT_W-1 -: DATA_WIDTH];
    assign ct_head_last = ct_rdata[CT_W-DATA_WIDTH-1];

`ifdef GCTR_DEC_PARTIAL_EN
    assign ct_wdata = {ct_data, ct_last, ct_bytes};
    assign pt_raw   = ct_head_last ?
                      ((ct_head ^ ks_rdata) & mask_msb(ct_rdata[BYTES_W-1:0])) :
                      (ct_head ^ ks_rdata);
`else
    logic unused_ct_bytes;
    assign unused_ct_bytes = ^ct_bytes;
    assign ct_wdata = {ct_data, ct_last};
    assign pt_raw   = ct_head ^ ks_rdata;
`endif

    assign pt_data        = pt_valid ? pt_raw : '0;
    assign pt_last        = pt_valid & ct_head_last;
    assign busy           = (state_q != IDLE);
    assign ciph_valid_out = ciph_valid_q;
    assign ciph_block_out = ciph_block_q;

    gcm_sync_fifo #(
        .WIDTH(CT_W),
        .DEPTH(DEPTH)
    ) u_ct_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (accept),
        .data_i (ct_wdata),
        .pop_i  (pt_fire),
        .data_o (ct_rdata),
        .empty_o(ct_empty),
        .full_o (unused_ct_full)
    );

    gcm_sync_fifo #(
        .WIDTH(DATA_WIDTH),
        .DEPTH(DEPTH)
    ) u_ks_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (ks_push),
        .data_i (ciph_block_in),
        .pop_i  (pt_fire),
        .data_o (ks_rdata),
        .empty_o(ks_empty),
        .full_o (ks_full)
    );

    // Next-state: FSM, counter block and outstanding credit count.
    always_comb begin
        state_d = state_q;
        cb_d    = cb_q;
        outst_d = outst_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cb_d    = icb_in;
                end
            end
            RUN: begin
                if (accept && ct_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pt_fire && pt_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (accept) begin
            cb_d = cb_inc;
        end
        unique case ({accept, pt_fire})
            2'b10:   outst_d = outst_q + 1'b1;
            2'b01:   outst_d = outst_q - 1'b1;
            default: outst_d = outst_q;
        endcase
    end

    // State registers, registered AES request and in-flight request tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cb_q         <= '0;
            outst_q      <= '0;
            pend_q       <= '0;
            ciph_valid_q <= 1'b0;
            ciph_block_q <= '0;
        end else begin
            state_q      <= state_d;
            cb_q         <= cb_d;
            outst_q      <= outst_d;
            pend_q       <= CIPH_LAT'({pend_q, ciph_valid_q});
            ciph_valid_q <= accept;
            if (accept) begin
                ciph_block_q <= cb_q;
            end
        end
    end

    // Keystream must never arrive with the keystream FIFO full.
    a_ks_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(ciph_valid_in && ks_full));

endmodule

// File: tb/tb_gctr_decrypt_stream.sv
// Self-checking bench for gctr_decrypt_stream with a fixed-latency AES stand-in
// (keystream = counter block + 1) and a queue-based reference model.
module tb_gctr_decrypt_stream;
    localparam int unsigned L = 12;
    localparam int unsigned D = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [127:0] icb_in = '0;
    logic         ct_valid = 1'b0;
    logic         ct_ready;
    logic [127:0] ct_data = '0;
    logic         ct_last = 1'b0;
    logic [4:0]   ct_bytes = 5'd16;
    logic         ciph_valid_out;
    logic [127:0] ciph_block_out;
    logic         ciph_valid_in;
    logic [127:0] ciph_block_in;
    logic         pt_valid;
    logic         pt_ready = 1'b1;
    logic [127:0] pt_data;
    logic         pt_last;
    logic         busy;

    always #5 clk = ~clk;

    gctr_decrypt_stream #(
        .DATA_WIDTH(128),
        .S         (32),
        .CIPH_LAT  (L),
        .DEPTH     (D)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .icb_in        (icb_in),
        .ct_valid      (ct_valid),
        .ct_ready      (ct_ready),
        .ct_data       (ct_data),
        .ct_last       (ct_last),
        .ct_bytes      (ct_bytes),
        .ciph_valid_out(ciph_valid_out),
        .ciph_block_out(ciph_block_out),
        .ciph_valid_in (ciph_valid_in),
        .ciph_block_in (ciph_block_in),
        .pt_valid      (pt_valid),
        .pt_ready      (pt_ready),
        .pt_data       (pt_data),
        .pt_last       (pt_last),
        .busy          (busy)
    );

    // AES stand-in: never reset, so keystream for requests issued before a reset still arrives.
    bit           aes_v [L];
    bit   [127:0] aes_b [L];
    always @(posedge clk) begin
        aes_v[0] <= ciph_valid_out;
        aes_b[0] <= ciph_block_out + 128'd1;
        for (int i = 1; i < int'(L); i++) begin
            aes_v[i] <= aes_v[i-1];
            aes_b[i] <= aes_b[i-1];
        end
    end
    assign ciph_valid_in = aes_v[L-1];
    assign ciph_block_in = aes_b[L-1];

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [127:0] msb_keep(input int k);
        logic [127:0] ones;
        ones = '1;
        return ones << (8 * (16 - k));
    endfunction

    // Reference model state.
    logic [127:0] cb_m;
    logic [127:0] exp_cb_q [$];
    logic [128:0] exp_pt_q [$];
    logic [127:0] obs_cb [$];
    logic [127:0] obs_pt [$];
    int           cyc = 0;
    int           acc_n = 0, pt_n = 0;
    int           acc_first = -1, pt_first = -1, pt_last_cyc = -1;
    bit           have_prev = 0;
    logic [127:0] prev_pt;

    // Monitor and scoreboard, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        logic [127:0] p;
        logic [128:0] e;
        cyc++;
        if (rst) begin
            exp_cb_q.delete();
            exp_pt_q.delete();
            have_prev = 0;
        end else begin
            if (ct_valid && ct_ready) begin
                exp_cb_q.push_back(cb_m);
                p = ct_data ^ (cb_m + 128'd1);
`ifdef GCTR_DEC_PARTIAL_EN
                if (ct_last) p = p & msb_keep(int'(ct_bytes));
`endif
                exp_pt_q.push_back({ct_last, p});
                cb_m = {cb_m[127:32], cb_m[31:0] + 32'd1};
                acc_n++;
                if (acc_first < 0) acc_first = cyc;
            end
            if (ciph_valid_out) begin
                obs_cb.push_back(ciph_block_out);
                chk("cb_expected", 128'(exp_cb_q.size() != 0), 1);
                if (exp_cb_q.size() != 0) chk("cb_value", ciph_block_out, exp_cb_q.pop_front());
            end
            if (have_prev) begin
                chk("pt_hold_valid", 128'(pt_valid), 1);
                chk("pt_hold_data", pt_data, prev_pt);
            end
            have_prev = pt_valid && !pt_ready;
            prev_pt   = pt_data;
            if (pt_valid && pt_first < 0) pt_first = cyc;
            if (pt_valid && pt_ready) begin
                obs_pt.push_back(pt_data);
                pt_n++;
                if (pt_last) pt_last_cyc = cyc;
                chk("pt_expected", 128'(exp_pt_q.size() != 0), 1);
                if (exp_pt_q.size() != 0) begin
                    e = exp_pt_q.pop_front();
                    chk("pt_data", pt_data, e[127:0]);
                    chk("pt_last", 128'(pt_last), 128'(e[128]));
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic start_msg(input logic [127:0] icb);
        icb_in = icb;
        cb_m   = icb;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic send_blk(input logic [127:0] d, input logic last, input logic [4:0] nb);
        int w;
        w = 0;
        ct_valid = 1'b1;
        ct_data  = d;
        ct_last  = last;
        ct_bytes = nb;
        @(negedge clk);
        while (!ct_ready && w < 300) begin
            step();
            @(negedge clk);
            w++;
        end
        chk("ct_accept", 128'(ct_ready), 1);
        step();
        ct_valid = 1'b0;
    endtask

    task automatic send_msg(input int n, input logic [127:0] icb, input logic [4:0] last_nb);
        start_msg(icb);
        for (int i = 0; i < n; i++) begin
            send_blk(rnd128(), i == n - 1,
                     (i == n - 1) ? last_nb : 5'($urandom_range(1, 16)));
        end
    endtask

    task automatic wait_idle();
        int w;
        w = 0;
        while ((busy || exp_pt_q.size() != 0) && w < 2000) begin
            step();
            w++;
        end
        chk("idle_reached", 128'(w < 2000), 1);
    endtask

    task automatic chk_outputs_zero(input string tag);
        @(negedge clk);
        chk({tag, "_ct_ready"}, 128'(ct_ready), 0);
        chk({tag, "_ciph_valid"}, 128'(ciph_valid_out), 0);
        chk({tag, "_ciph_block"}, ciph_block_out, 0);
        chk({tag, "_pt_valid"}, 128'(pt_valid), 0);
        chk({tag, "_pt_data"}, pt_data, 0);
        chk({tag, "_pt_last"}, 128'(pt_last), 0);
        chk({tag, "_busy"}, 128'(busy), 0);
    endtask

    initial begin
        logic [127:0] v;
        logic [95:0]  up;
        int           n0;

        // Reset state.
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        chk_outputs_zero("reset");
        step();

        // Single block, all-zero ciphertext: plaintext equals keystream.
        obs_pt.delete();
        start_msg({96'h0, 32'h2});
        send_blk('0, 1'b1, 5'd16);
        wait_idle();
        chk("single_count", 128'(obs_pt.size()), 1);
        if (obs_pt.size() != 0) chk("single_pt", obs_pt[0], {96'h0, 32'h3});
        repeat (2) step();
        chk("single_busy", 128'(busy), 0);

        // 64-block burst at full rate.
        acc_first = -1;
        pt_first  = -1;
        n0        = pt_n;
        send_msg(64, rnd128(), 5'd16);
        wait_idle();
        chk("burst_latency", 128'(pt_first - acc_first), 128'(L + 2));
        chk("burst_rate", 128'(pt_last_cyc - pt_first), 63);
        chk("burst_count", 128'(pt_n - n0), 64);

        // Counter wrap in the low 32 bits.
        up = {$urandom, $urandom, $urandom};
        obs_cb.delete();
        send_msg(3, {up, 32'hFFFF_FFFE}, 5'd16);
        wait_idle();
        chk("wrap_count", 128'(obs_cb.size()), 3);
        if (obs_cb.size() == 3) begin
            chk("wrap_cb0", obs_cb[0], {up, 32'hFFFF_FFFE});
            chk("wrap_cb1", obs_cb[1], {up, 32'hFFFF_FFFF});
            chk("wrap_cb2", obs_cb[2], {up, 32'h0000_0000});
        end

        // Backpressure, with a start pulse mid-message that must be ignored.
        pt_ready = 1'b0;
        acc_n    = 0;
        n0       = pt_n;
        fork
            send_msg(24, rnd128(), 5'd16);
            begin
                repeat (5) step();
                icb_in = rnd128();
                start  = 1'b1;
                step();
                start  = 1'b0;
                repeat (34) step();
                @(negedge clk);
                chk("bp_ct_ready", 128'(ct_ready), 0);
                chk("bp_accepted", 128'(acc_n), 128'(D));
                chk("bp_pt_valid", 128'(pt_valid), 1);
                step();
                pt_ready = 1'b1;
            end
        join
        wait_idle();
        chk("bp_count", 128'(pt_n - n0), 24);

`ifdef GCTR_DEC_PARTIAL_EN
        // Partial last block of 5 bytes.
        obs_pt.delete();
        send_msg(2, rnd128(), 5'd5);
        wait_idle();
        chk("partial_count", 128'(obs_pt.size()), 2);
        if (obs_pt.size() == 2) begin
            v = obs_pt[1];
            chk("partial_low_zero", 128'(v[87:0]), 0);
        end
`endif

        // Reset with six requests in flight; late keystream must not leak into the next message.
        start_msg(rnd128());
        for (int i = 0; i < 6; i++) send_blk(rnd128(), 1'b0, 5'd16);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_outputs_zero("midrst");
        n0 = pt_n;
        send_msg(4, rnd128(), 5'd16);
        wait_idle();
        chk("midrst_count", 128'(pt_n - n0), 4);
        repeat (L + 4) step();
        chk("midrst_quiet", 128'(pt_valid), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
